frame_dump_tx: RTL and testbench
================================

# frame_dump_tx

Streams a stored image frame out of the board over UART so the PC can capture the processed result. On a start pulse it reads every pixel byte of the frame RAM in address order and transmits each as one 8N1 UART frame. It is the return path of the UART-receive → FIFO/Sobel → frame-RAM → VGA chain: it shares the RAM read port and drives the board `tx` pin.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, sclk frequency in Hz.
- `BAUD`, 9600, UART bit rate; `BAUD_DIV = CLK_FREQ/BAUD` (integer division, must be ≥ 4).
- `PIX_NUM`, 10000, number of pixel bytes per frame (≥ 1).
- `ADDR_W`, 14, RAM address width; must satisfy 2^ADDR_W ≥ PIX_NUM.

Ports:
- `sclk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to dump a frame; ignored while `busy`=1.
- `rd_en` out 1: RAM read strobe, high for one cycle per pixel.
- `rd_addr` out ADDR_W: RAM read address.
- `rd_data` in 8: RAM read data, valid exactly 1 cycle after `rd_en`.
- `tx` out 1: UART serial out, idle high.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last stop bit.

Reset values: `tx`=1, `rd_en`=0, `rd_addr`=0, `busy`=0, `done`=0.

## Operation
- FSM states: IDLE, HDR (only with macro), FETCH, LATCH, SEND, WAIT, FIN.
- IDLE: `start`=1 → FETCH (or HDR). `rd_addr`=0 and `busy`=1 from the next cycle.
- FETCH: `rd_en`=1 for one cycle at the current `rd_addr` → LATCH.
- LATCH: capture `rd_data` into the byte register → SEND.
- SEND: pulse `tx_start` to the byte transmitter with the latched byte → WAIT.
- WAIT: on the transmitter `tx_done`:
  - if `rd_addr` = PIX_NUM-1 → FIN;
  - else `rd_addr`+1 → FETCH.
- FIN: `done`=1 and `busy`=0 in the same cycle → IDLE.
- UART frame: start bit 0, data bits LSB first, one stop bit 1; each bit lasts exactly BAUD_DIV cycles. `tx_done` is high in the last cycle of the stop bit.
- `rd_addr` stays at PIX_NUM-1 after completion. It resets to 0 only on the next accepted `start`; there is no wrap past PIX_NUM-1.
- `start` during `busy` is dropped, not queued. `start` in the FIN cycle is also ignored.
- Reset mid-frame: `tx` goes high immediately (asynchronous); the partial byte is abandoned; no `done` pulse.

## Timing
- `start` sampled high at edge 0:
  - FETCH at cycle 1 (`rd_en`=1, `rd_addr`=0);
  - LATCH at cycle 2;
  - SEND at cycle 3;
  - `tx` falls at cycle 4.
- Between bytes, `tx` stays high for 3 cycles (FETCH/LATCH/SEND) after the stop bit ends.
- Per-byte period: 10·BAUD_DIV + 3 cycles.
- `done` comes 1 cycle after the last `tx_done`.
- Total time from `start` to `done`: 3 + PIX_NUM·(10·BAUD_DIV+3) − 3 + 1 cycles, measured from edge 0.

## Configuration
- `FRAME_HEADER_EN` defined:
  - after `start`, the block sends header byte 0xA5 and then 0x5A in state HDR, before the first FETCH;
  - each header byte takes one SEND→WAIT cycle, with 1 idle cycle between bytes;
  - the first FETCH comes 1 cycle after the second header's `tx_done`.
- Not defined: HDR is absent, and the first FETCH is at cycle 1 as above.

## Structure
- Package `frame_dump_pkg` holds:
  - the state enum;
  - header constants `HDR0`=8'hA5 and `HDR1`=8'h5A;
  - the `BAUD_DIV` calculation function.
- Sub-module `uart_byte_tx` (inputs `tx_start`, `tx_data`[7:0]; outputs `tx`, `tx_busy`, `tx_done`) contains:
  - the bit-period counter (width clog2(BAUD_DIV));
  - a 4-bit bit index;
  - the shift register.
- The top level holds the FSM and the address counter.

## Test plan
Bench settings: CLK_FREQ=16, BAUD=1 (BAUD_DIV=16), PIX_NUM=4, RAM preloaded with 0x00, 0xFF, 0x5A, 0x81.
- Single dump: `start` pulse → `tx` decodes 0x00, 0xFF, 0x5A, 0x81; `rd_addr` sequence is 0,1,2,3; `done` at cycle 3+4·163−3+1 = 653.
- Bit timing: for byte 0x81, the start bit lasts 16 cycles low, then the data bits are 1,0,0,0,0,0,0,1 with 16 cycles each, then the stop bit is 16 cycles high; the first `tx` fall is at cycle 4.
- Start while busy: a second `start` at cycle 100 → no effect; still exactly 4 bytes and one `done`.
- Mid-frame reset: `rst_n` low at cycle 200 → `tx`=1, `busy`=0 and `rd_addr`=0 immediately; no `done`. A subsequent `start` → a full correct dump.
- Back-to-back frames: `start` in the cycle after `done` → second dump identical, `rd_addr` restarts at 0.
- With `FRAME_HEADER_EN`: the stream is 0xA5, 0x5A, then the 4 pixels, and the first `rd_en` occurs 1 cycle after the second header's `tx_done`.

Source files
------------

// File: rtl/frame_dump_pkg.sv
// Shared types and constants for the frame_dump_tx UART frame dumper.
// The optional FRAME_HEADER_EN build uses the header byte constants below.
package frame_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_WAIT,
        ST_FIN
    } state_t;

    localparam logic [7:0] HDR0 = 8'hA5;
    localparam logic [7:0] HDR1 = 8'h5A;

    // Bit index of the stop bit in a 10-bit 8N1 frame (0 = start bit).
    localparam logic [3:0] STOP_IDX = 4'd9;

    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/frame_dump_tx_uart.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, one stop bit,
// each held for exactly BAUD_DIV clock cycles.
module uart_byte_tx
    import frame_dump_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (!busy_q) begin
            if (tx_start) begin
                busy_d  = 1'b1;
                cnt_d   = '0;
                idx_d   = '0;
                shift_d = tx_data;
                tx_d    = 1'b0;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == STOP_IDX) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                idx_d = idx_q + 4'd1;
                if (idx_q == STOP_IDX - 4'd1) begin
                    tx_d = 1'b1;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = busy_q && (idx_q == STOP_IDX) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/frame_dump_tx.sv
// Dumps PIX_NUM bytes of frame RAM over UART on a start pulse.
// Define FRAME_HEADER_EN to prefix each dump with header bytes 0xA5, 0x5A.
module frame_dump_tx
    import frame_dump_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int PIX_NUM  = 10000,
    parameter int ADDR_W   = 14
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int                 BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_NUM - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_en_q, rd_en_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          byte_q, byte_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tx_busy, tx_done;
`ifdef FRAME_HEADER_EN
    logic                hdr_idx_q, hdr_idx_d;
`endif

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = 1'b0;
        tx_start_d = 1'b0;
        byte_d     = byte_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef FRAME_HEADER_EN
        hdr_idx_d  = hdr_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !tx_busy) begin
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
`ifdef FRAME_HEADER_EN
                    state_d    = ST_HDR;
                    hdr_idx_d  = 1'b0;
                    byte_d     = HDR0;
                    tx_start_d = 1'b1;
`else
                    state_d = ST_FETCH;
                    rd_en_d = 1'b1;
`endif
                end
            end
`ifdef FRAME_HEADER_EN
            // Second header byte launches one idle cycle after the first one's stop bit.
            ST_HDR: begin
                if (tx_done) begin
                    if (!hdr_idx_q) begin
                        hdr_idx_d  = 1'b1;
                        byte_d     = HDR1;
                        tx_start_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        rd_en_d = 1'b1;
                    end
                end
            end
`endif
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                byte_d     = rd_data;
                tx_start_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        rd_en_d   = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            byte_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef FRAME_HEADER_EN
            hdr_idx_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            tx_start_q <= tx_start_d;
            byte_q     <= byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef FRAME_HEADER_EN
            hdr_idx_q  <= hdr_idx_d;
`endif
        end
    end

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .tx_start (tx_start_q),
        .tx_data  (byte_q),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_frame_dump_tx.sv
// Scoreboard bench for frame_dump_tx: a UART decoder pops expected bytes
// while directed stimulus drives start/reset scenarios.
module tb_frame_dump_tx;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int PIX_NUM  = 4;
    localparam int ADDR_W   = 2;
    localparam int BD       = 16;
`ifdef FRAME_HEADER_EN
    localparam int FETCH_CYC  = 323;
    localparam int FIRST_FALL = 2;
    localparam int DONE_CYC   = 975;
`else
    localparam int FETCH_CYC  = 1;
    localparam int FIRST_FALL = 4;
    localparam int DONE_CYC   = 653;
`endif

    logic              sclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = 8'h00;
    logic              tx, busy, done;

    logic [7:0] ram [PIX_NUM] = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    logic [7:0] exp_q [$];
    int         addr_log [$];
    int         n_cmp = 0, n_bad = 0;
    int         pcount = 0, done_cnt = 0;
    int         first_fall = -1, first_rden = -1;

    frame_dump_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .PIX_NUM  (PIX_NUM),
        .ADDR_W   (ADDR_W)
    ) dut (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .start   (start),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) begin
        pcount++;
        if (rd_en) rd_data <= ram[rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, pcount);
        end
    endtask

    always @(negedge sclk) begin
        if (rst_n && done === 1'b1) done_cnt++;
        if (rst_n && rd_en === 1'b1) addr_log.push_back(int'(rd_addr));
        if (rst_n && first_fall < 0 && tx === 1'b0) first_fall = pcount;
        if (rst_n && first_rden < 0 && rd_en === 1'b1) first_rden = pcount;
    end

    // UART decoder / scoreboard monitor: 160 samples per frame, one per cycle.
    initial begin
        logic s [160];
        logic [7:0] b;
        bit shape_ok, aborted;
        forever begin
            @(negedge sclk);
            if (rst_n && tx === 1'b0) begin
                s[0] = tx;
                aborted = 1'b0;
                for (int i = 1; i < 160; i++) begin
                    @(negedge sclk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = tx;
                end
                if (!aborted) begin
                    shape_ok = (s[0] === 1'b0) && (s[144] === 1'b1);
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < BD; j++)
                            if (s[k*BD+j] !== s[k*BD]) shape_ok = 1'b0;
                    for (int k = 0; k < 8; k++) b[k] = s[(k+1)*BD];
                    check("frame_shape", 32'(shape_ok), 1);
                    check("byte_pending", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("tx_byte", 32'(b), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic wait_cycle(input int t0, input int n);
        while (pcount < t0 + n) @(negedge sclk);
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic start_dump(output int t0);
`ifdef FRAME_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
`endif
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h81);
        addr_log.delete();
        first_fall = -1;
        first_rden = -1;
        start = 1'b1;
        t0 = pcount;
        @(negedge sclk);
        start = 1'b0;
    endtask

    task automatic finish_dump(input int t0);
        int at;
        at = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sclk);
            if (done === 1'b1) begin
                at = pcount - t0;
                break;
            end
        end
        check("done_cycle", at, DONE_CYC);
        check("busy_at_done", 32'(busy), 0);
        check("rd_addr_final", 32'(rd_addr), PIX_NUM - 1);
        check("first_tx_fall", first_fall - t0, FIRST_FALL);
        check("first_rd_en", first_rden - t0, FETCH_CYC);
        check("rd_addr_count", addr_log.size(), PIX_NUM);
        for (int i = 0; i < PIX_NUM; i++)
            check("rd_addr_seq", (i < addr_log.size()) ? addr_log[i] : -1, i);
    endtask

    initial begin
        int t0, dc;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", pcount);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, dc;
        repeat (3) @(negedge sclk);
        check("rst_tx", 32'(tx), 1);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge sclk);

        // Dump A, with a dropped start at cycle 100.
        start_dump(t0);
        check("busy_cycle1", 32'(busy), 1);
        check("rd_addr_cycle1", 32'(rd_addr), 0);
        wait_cycle(t0, 100);
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        finish_dump(t0);

        // Start held through FIN (ignored) and the following cycle (accepted).
        start = 1'b1;
        @(negedge sclk);
        start_dump(t0);
        check("b2b_busy", 32'(busy), 1);
        check("b2b_rd_addr_restart", 32'(rd_addr), 0);
        check("done_count_a", done_cnt, 1);
        finish_dump(t0);

        // Mid-frame reset at cycle 200.
        @(negedge sclk);
        start_dump(t0);
        wait_cycle(t0, 200);
        check("busy_before_reset", 32'(busy), 1);
        dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("reset_tx", 32'(tx), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_rd_addr", 32'(rd_addr), 0);
        exp_q.delete();
        repeat (4) @(negedge sclk);
        rst_n = 1'b1;
        repeat (30) @(negedge sclk);
        check("no_done_after_reset", done_cnt, dc);
        check("idle_tx_after_reset", 32'(tx), 1);

        // Full dump after reset.
        start_dump(t0);
        finish_dump(t0);

        repeat (200) @(negedge sclk);
        check("bytes_left", exp_q.size(), 0);
        check("done_total", done_cnt, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
